// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state type and size defaults for the sequence detector
package seq_detect_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HOLD = 2'd2} state_t;
  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int LEN_W = $clog2(PAT_W_DEF) + 1;
endpackage

// File: rtl/seq_match_window.sv
// seq_match_window: bit history, fill counter and length-masked pattern compare
module seq_match_window
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LW = LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clr_fill,
  input  logic             clr_all,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pat,
  input  logic [LW-1:0]    len,
  output logic             hit
);
  logic [PAT_W-2:0] hist;
  logic [LW-1:0] fill;
  logic [PAT_W-1:0] win, mask;
  assign win = {hist, bit_in};
  assign mask = ~({PAT_W{1'b1}} << len);
  assign hit = (fill >= len - LW'(1)) && (((win ^ pat) & mask) == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr_all) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= win[PAT_W-2:0];
      fill <= clr_fill ? '0 : (fill >= len ? len : fill + LW'(1));
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with arm/hold control and match counting
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [PAT_W-1:0]     cfg_pat,
  input  logic [$clog2(PAT_W):0] cfg_len,
  input  logic                 cfg_ovl,
  input  logic [CNT_W-1:0]     cfg_target,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 bit_in,
  input  logic                 bit_vld,
  output logic                 match,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 done,
  output logic                 busy,
  output logic                 cfg_err,
  output logic [1:0]           state
);
  localparam int LW = $clog2(PAT_W) + 1;
  state_t st;
  logic [PAT_W-1:0] pat;
  logic [LW-1:0] len;
  logic ovl, hit, len_ok;
  logic [CNT_W-1:0] tgt, cnt_inc;
  assign len_ok = (cfg_len >= LW'(2)) && (cfg_len <= LW'(PAT_W));
  assign match = (st == ARMED) && bit_vld && hit;
  assign cnt_inc = &match_cnt ? match_cnt : match_cnt + CNT_W'(1);
  assign state = st;
  seq_match_window #(.PAT_W(PAT_W), .LW(LW)) u_win (
    .clk(clk),
    .rst(rst),
    .shift((st == ARMED) && bit_vld),
    .clr_fill(match && !ovl),
    .clr_all(start || stop),
    .bit_in(bit_in),
    .pat(pat),
    .len(len),
    .hit(hit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      match_cnt <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      cfg_err <= 1'b0;
      pat <= '0;
      len <= LW'(2);
      ovl <= 1'b0;
      tgt <= '0;
    end else begin
      cfg_err <= cfg_we && (st != IDLE || !len_ok);
      if (cfg_we && st == IDLE && len_ok) begin
        pat <= cfg_pat;
        len <= cfg_len;
        ovl <= cfg_ovl;
        tgt <= cfg_target;
      end
      if (stop) begin
        st <= IDLE;
        done <= 1'b0;
        busy <= 1'b0;
      end else if (start) begin
        st <= ARMED;
        match_cnt <= '0;
        done <= 1'b0;
        busy <= 1'b1;
      end else if (match) begin
        match_cnt <= cnt_inc;
        if (tgt != '0 && cnt_inc == tgt) begin
          st <= HOLD;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run-time controller for the serial sequence-detection datapath. It holds a programmable pattern and length and arms and disarms detection. It feeds qualified bits into a matching window, supports overlapping and non-overlapping match modes, and counts matches up to a target. On reaching the target it halts and flags done. It sits between the top-level pin wrapper (ui_in/uo_out) and the detection window, replacing fixed hard-coded detectors.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high; one clock domain only
cfg_we  in  1  config write strobe, honoured only in IDLE
cfg_pat  in  PAT_W  pattern; first-received bit compares with cfg_pat[len-1], last with cfg_pat[0]
cfg_len  in  $clog2(PAT_W)+1  active pattern length; valid range 2..PAT_W
cfg_ovl  in  1  1 = overlapping matches, 0 = non-overlapping
cfg_target  in  CNT_W  matches before done; 0 = run forever
start  in  1  arm detection (IDLE→ARMED)
stop  in  1  abort/clear (any state→IDLE)
bit_in  in  1  serial data bit
bit_vld  in  1  bit_in qualifier
match  out  1  Mealy pulse: high in the cycle the completing bit is presented
match_cnt  out  CNT_W  matches since last start
done  out  1  level; high in HOLD
busy  out  1  high in ARMED
cfg_err  out  1  one-cycle pulse: rejected config write
state  out  2  IDLE=0, ARMED=1, HOLD=2

Behaviour:
- Reset values: state=IDLE; match=0, match_cnt=0, done=0, busy=0, cfg_err=0; pattern regs=0, len=2, ovl=0, target=0; history and fill cleared.
- IDLE:
  - cfg_we with cfg_len in 2..PAT_W latches all cfg_* on the next edge.
  - cfg_we with cfg_len outside that range latches nothing and pulses cfg_err the next cycle.
  - start → ARMED; clears match_cnt, history, fill.
- cfg_we in ARMED or HOLD: ignored, and cfg_err pulses.
- ARMED:
  - Each bit_vld cycle shifts bit_in into history; fill increments, saturating at len.
  - Match condition: bit_vld & (fill ≥ len-1) & ({history[len-2:0], bit_in} == pat[len-1:0]).
  - match is combinational from bit_in/bit_vld; zero latency.
  - No bit_vld: no shift, no match.
- On a match:
  - match_cnt increments, saturating at all-ones.
  - Non-overlap (ovl=0): fill clears to 0, so the next match needs len fresh bits.
  - Overlap (ovl=1): history is retained.
- Target reached: if target≠0 and the incremented count == target, go to HOLD on the same edge.
- HOLD: bits ignored, match=0, count frozen; start → ARMED with counter, history and fill cleared.
- stop in any state → IDLE on the next edge; clears history and fill; match_cnt is kept for readout.
- start and stop asserted together: stop wins.
- start while ARMED: restarts; counter, history and fill cleared.
- Async rst mid-stream: immediate return to reset values; config lost.

Decomposition:
- Shared package seq_detect_pkg:
  - state enum (IDLE, ARMED, HOLD)
  - PAT_W/CNT_W defaults
  - LEN_W = $clog2(PAT_W)+1
- Sub-module seq_match_window: history shift register, fill counter, masked compare.
  - Inputs: clk, rst, shift, clr_fill, clr_all, bit_in, pat, len.
  - Output: hit.
- Controller FSM, counter, and config regs live in seq_detect_ctrl.

Test Plan:
1. cfg pat=5'b11011, len=5, ovl=0, target=0; start; stream 1,1,0,1,1,0,1,1 → match only at bit 5; match_cnt=1.
2. Same stream with ovl=1 → match at bits 5 and 8; match_cnt=2.
3. ovl=1, target=2; stream 1,1,0,1,1,0,1,1,0,1,1 → done=1 and state=HOLD after bit 8; bits 9–11 give no match; match_cnt stays 2.
4. cfg_len=0, then cfg_len=PAT_W+1 → cfg_err pulses each time; config unchanged. cfg_we while ARMED → cfg_err pulses; pattern unchanged.
5. Stream 1,1,0,1, then stop, start, then bits 1,1 → no match; history was cleared. Continue with 0,1,1 → match at that 5th bit.
6. Gaps: bit_vld low for 3 cycles mid-pattern → gaps ignored; match still fires on the completing bit. rst pulsed mid-stream → all outputs go to reset values immediately; match_cnt=0.
